// File: rtl/ram_fifo_ctrl.sv
// Purpose: FIFO controller driving both ports of a dual-port RAM (A = write, B = read).
// Latency: push readable WRITE_LANTENCY edges after accept; pop data valid READ_LANTENCY edges after accept.
// Backpressure: o_full refuses pushes, o_empty refuses pops (o_wr_err / o_rd_err pulse); no output backpressure.
module ram_fifo_ctrl #(
    parameter int ADDR_WIDTH     = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int READ_LANTENCY  = 3,
    parameter int WRITE_LANTENCY = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_full,
    input  logic                  i_rd_en,
    output logic                  o_empty,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_valid,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_wr_err,
    output logic                  o_rd_err,
    output logic [ADDR_WIDTH-1:0] o_ram_addra,
    output logic [DATA_WIDTH-1:0] o_ram_dina,
    output logic                  o_ram_ena,
    output logic                  o_ram_wea,
    output logic [ADDR_WIDTH-1:0] o_ram_addrb,
    output logic [DATA_WIDTH-1:0] o_ram_dinb,
    output logic                  o_ram_enb,
    output logic                  o_ram_web,
    input  logic [DATA_WIDTH-1:0] i_ram_doutb
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    // occupancy counts every slot not yet released; committed counts entries safe to pop
    logic [CNT_W-1:0]      occ_q, occ_d;
    logic [CNT_W-1:0]      com_q, com_d;
    logic                  full_q, empty_q;
    logic                  wr_err_q, rd_err_q;
    logic [WRITE_LANTENCY-1:0] commit_sr_q;
    // one stage more than READ_LANTENCY: the last stage is the registered o_rd_valid itself,
    // so valid lands READ_LANTENCY edges after the accepting edge
    logic [READ_LANTENCY:0]    rvld_sr_q;

    logic wr_acc, rd_acc, commit_out, release_slot;

    // accept decisions and next-state arithmetic for pointers and counters
    always_comb begin
        wr_acc       = i_wr_en & ~full_q & ~i_rst;
        rd_acc       = i_rd_en & ~empty_q & ~i_rst;
        commit_out   = commit_sr_q[WRITE_LANTENCY-1];
        release_slot = rvld_sr_q[READ_LANTENCY];
        wr_ptr_d     = wr_acc ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
        rd_ptr_d     = rd_acc ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
        // a slot is freed only when its read data returns, so an in-flight read is never overwritten
        occ_d        = occ_q + CNT_W'(wr_acc) - CNT_W'(release_slot);
        com_d        = com_q + CNT_W'(commit_out) - CNT_W'(rd_acc);
    end

    // pointers, counters and registered flags
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            com_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            wr_err_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            com_q    <= com_d;
            full_q   <= (occ_d == DEPTH);
            empty_q  <= (com_d == '0);
            wr_err_q <= i_wr_en & full_q;
            rd_err_q <= i_rd_en & empty_q;
        end
    end

    // write-commit and read-valid delay lines; reset drops everything in flight
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            commit_sr_q <= '0;
            rvld_sr_q   <= '0;
        end else begin
            commit_sr_q[0] <= wr_acc;
            for (int i = 1; i < WRITE_LANTENCY; i++) begin
                commit_sr_q[i] <= commit_sr_q[i-1];
            end
            rvld_sr_q[0] <= rd_acc;
            for (int i = 1; i <= READ_LANTENCY; i++) begin
                rvld_sr_q[i] <= rvld_sr_q[i-1];
            end
        end
    end

    // RAM port A: write-only, driven in the accept cycle
    assign o_ram_ena   = wr_acc;
    assign o_ram_wea   = wr_acc;
    assign o_ram_addra = wr_ptr_q;
    assign o_ram_dina  = wr_acc ? i_wr_data : '0;

    // RAM port B: read-only, driven in the accept cycle
    assign o_ram_enb   = rd_acc;
    assign o_ram_web   = 1'b0;
    assign o_ram_addrb = rd_ptr_q;
    assign o_ram_dinb  = '0;

    assign o_rd_valid  = rvld_sr_q[READ_LANTENCY];
    assign o_rd_data   = i_ram_doutb;
    assign o_full      = full_q;
    assign o_empty     = empty_q;
    assign o_count     = occ_q;
    assign o_wr_err    = wr_err_q;
    assign o_rd_err    = rd_err_q;

endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
Synchronous FIFO controller that sits directly upstream of dual_port_ram and owns both of its ports. Port A is the write port and port B is the read port. The block turns a push/pop stream interface into RAM enables and addresses. It hides the RAM's write and read latencies: it only exposes data as readable once the write has committed, and it returns read data with a valid strobe.

Parameters:
ADDR_WIDTH, 5, RAM address width; FIFO depth DEPTH = 2^ADDR_WIDTH.
DATA_WIDTH, 32, data width.
READ_LANTENCY, 3, RAM read latency in clock edges, >=1; must match the RAM instance.
WRITE_LANTENCY, 3, clock edges from a write being issued until it is readable, >=1; must match the RAM instance.

Ports:
i_clk  input  1  clock; also drives both RAM port clocks.
i_rst  input  1  synchronous, active-high reset.
i_wr_en  input  1  push request.
i_wr_data  input  DATA_WIDTH  push data.
o_full  output  1  no free slot; a push is refused.
i_rd_en  input  1  pop request.
o_empty  output  1  no committed entry; a pop is refused.
o_rd_data  output  DATA_WIDTH  pop data, qualified by o_rd_valid.
o_rd_valid  output  1  o_rd_data is valid this cycle.
o_count  output  ADDR_WIDTH+1  occupancy.
o_wr_err  output  1  one-cycle pulse: a push was refused.
o_rd_err  output  1  one-cycle pulse: a pop was refused.
o_ram_addra, o_ram_dina, o_ram_ena, o_ram_wea  output  ADDR_WIDTH/DATA_WIDTH/1/1  RAM port A.
o_ram_addrb, o_ram_dinb, o_ram_enb, o_ram_web  output  ADDR_WIDTH/DATA_WIDTH/1/1  RAM port B.
i_ram_doutb  input  DATA_WIDTH  RAM port B read data.

Behaviour:
- Clocking and reset: single clock i_clk; reset i_rst is synchronous and active-high.
- Reset state:
  - wr_ptr, rd_ptr, occupancy and committed count are 0.
  - The commit and read-valid shift registers are cleared.
  - Outputs: o_empty=1, o_full=0, o_count=0, o_rd_valid=0, o_wr_err=0, o_rd_err=0.
  - RAM contents are not touched.
  - A reset in the middle of an operation drops all in-flight reads: no o_rd_valid appears after the reset edge.
- Push accept: wr_acc = i_wr_en & !o_full & !i_rst.
  - In the same cycle, combinationally: o_ram_ena=o_ram_wea=1, o_ram_addra=wr_ptr, o_ram_dina=i_wr_data.
  - At the edge: wr_ptr increments and wraps DEPTH-1 -> 0; occupancy increments.
  - The write enters a WRITE_LANTENCY-deep commit shift register.
- Commit: when a commit bit exits the shift register, the committed count increments.
  - o_empty = (committed count == 0), registered.
- Pop accept: rd_acc = i_rd_en & !o_empty & !i_rst.
  - In the same cycle: o_ram_enb=1, o_ram_web=0, o_ram_addrb=rd_ptr, o_ram_dinb=0.
  - At the edge: rd_ptr increments and wraps; committed count decrements.
- Read return:
  - o_rd_valid is asserted exactly READ_LANTENCY edges after the accepting edge, driven by a valid shift register.
  - o_rd_data = i_ram_doutb, passed through.
  - There is no output backpressure.
- Slot release: occupancy decrements on the o_rd_valid cycle, not at pop accept, so a slot is never overwritten while a read of it is in flight.
- Flags:
  - o_full = (occupancy == DEPTH); o_count = occupancy.
  - Both are registered and updated the edge after the event.
- Simultaneous events:
  - Push and pop in the same cycle are both evaluated against the current flags and update counters independently.
  - A pop freeing space does not unblock a push in the same cycle.
  - A commit and a pop in the same cycle give a net change of 0 to the committed count.
  - A release and a push in the same cycle give a net change of 0 to occupancy.
- Refused requests:
  - Push while o_full: o_wr_err=1 the next cycle, port A idle, no state change.
  - Pop while o_empty: o_rd_err=1 the next cycle, port B idle.
- Idle: all RAM enables and write-enables are 0; addresses hold their pointer values; data buses are 0.

Test Plan:
(All scenarios use default parameters.)
1. Reset: hold i_rst 2 cycles -> o_empty=1, o_full=0, o_count=0, o_rd_valid=0, all RAM enables 0.
2. Single push then pop:
   - Push 0x12 at edge N -> o_ram_addra=0, ena=wea=1 in cycle N; o_count=1 after N; o_empty falls after edge N+3.
   - Pop at edge M -> o_ram_addrb=0, enb=1; o_rd_valid=1 with data 0x12 in the cycle after edge M+3.
3. Fill: 32 pushes -> o_full=1, o_count=32. A 33rd push -> o_wr_err pulse, ena=0, o_count stays 32.
4. Pop while empty right after reset -> o_rd_err pulse, enb=0, no o_rd_valid ever.
5. Wrap:
   - Stream 40 pushes of 0x100+i with concurrent pops.
   - Required: addresses wrap 31->0; read data order is 0x100..0x127 with no loss; o_full is never asserted when occupancy is <32.
6. Reset mid-operation: assert i_rst with 2 pops in flight -> no o_rd_valid afterwards; flags return to reset values the following cycle.
